// File: rtl/jump_target_unit_pkg.sv
// Shared constants for the jump target unit: operation mode encodings and
// default parameter values.
package jtu_pkg;
    localparam logic [1:0] MODE_J   = 2'b00;
    localparam logic [1:0] MODE_JAL = 2'b01;
    localparam logic [1:0] MODE_JR  = 2'b10;
    localparam logic [1:0] MODE_BR  = 2'b11;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_IDX_W     = 26;
    localparam int DEF_IMM_W     = 16;
    localparam int DEF_RAS_DEPTH = 4;
endpackage

// File: rtl/jump_target_unit_if.sv
// Request/result bundle between the decode stage and the jump target unit.
interface jump_target_unit_if
    import jtu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int IMM_W  = DEF_IMM_W
);
    logic              Valid;
    logic [1:0]        Mode;
    logic [ADDR_W-1:0] PCAddResult;
    logic [IDX_W-1:0]  InstrIndex;
    logic [IMM_W-1:0]  Imm;
    logic              Flush;
    logic [ADDR_W-1:0] Target;
    logic              TargetValid;
    logic              RasEmpty;
    logic              RasOverflow;
    logic              RasUnderflow;

    modport master (
        output Valid, Mode, PCAddResult, InstrIndex, Imm, Flush,
        input  Target, TargetValid, RasEmpty, RasOverflow, RasUnderflow
    );

    modport slave (
        input  Valid, Mode, PCAddResult, InstrIndex, Imm, Flush,
        output Target, TargetValid, RasEmpty, RasOverflow, RasUnderflow
    );
endinterface

// File: rtl/jump_target_unit_ras.sv
// Circular return-address stack: r_ptr names the next free slot, so the top
// entry is r_ptr-1 and a push onto a full stack lands on the oldest entry.
module ras_stack
    import jtu_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
)(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic [PTR_W-1:0]  w_top_idx;
    logic              w_push;
    logic              w_pop;

    assign w_push    = push && !flush;
    assign w_pop     = pop && !flush;
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign dout      = r_mem[w_top_idx];
    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(RAS_DEPTH));
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // Entry contents need no reset; only pointer and count define validity.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_ptr] <= din;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_push && full;
            r_underflow <= w_pop && empty;
            if (flush) begin
                r_ptr   <= '0;
                r_count <= '0;
            end else if (w_push) begin
                r_ptr <= r_ptr + PTR_W'(1);
                if (!full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_pop && !empty) begin
                r_ptr   <= w_top_idx;
                r_count <= r_count - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/jump_target_unit.sv
// Registered jump/branch target generator for the ID/EX boundary; JR targets
// come from the return-address stack filled by JAL.
module jump_target_unit
    import jtu_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int IMM_W     = DEF_IMM_W,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
)(
    input logic               Clk,
    input logic               Reset_n,
    jump_target_unit_if.slave bus
);
    logic              w_op;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_jump_target;
    logic [ADDR_W-1:0] w_imm_ext;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_ras_dout;
    logic              w_ras_empty;
    logic              w_unused_ras_full;
    logic              w_ras_overflow;
    logic              w_ras_underflow;
    logic [ADDR_W-1:0] w_target_next;
    logic              w_target_valid_next;
    logic [ADDR_W-1:0] r_target;
    logic              r_target_valid;

    // A flush in the same cycle cancels the request entirely.
    assign w_op   = bus.Valid && !bus.Flush;
    assign w_push = w_op && (bus.Mode == MODE_JAL);
    assign w_pop  = w_op && (bus.Mode == MODE_JR);

    assign w_jump_target = {bus.PCAddResult[ADDR_W-1:IDX_W+2], bus.InstrIndex, 2'b00};
    assign w_imm_ext     = {{(ADDR_W-IMM_W){bus.Imm[IMM_W-1]}}, bus.Imm};
    assign w_br_target   = bus.PCAddResult + (w_imm_ext << 2);

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .push      (w_push),
        .pop       (w_pop),
        .flush     (bus.Flush),
        .din       (bus.PCAddResult),
        .dout      (w_ras_dout),
        .empty     (w_ras_empty),
        .full      (w_unused_ras_full),
        .overflow  (w_ras_overflow),
        .underflow (w_ras_underflow)
    );

    always_comb begin
        w_target_next       = r_target;
        w_target_valid_next = 1'b0;
        if (w_op) begin
            w_target_valid_next = 1'b1;
            unique case (bus.Mode)
                MODE_J, MODE_JAL: w_target_next = w_jump_target;
                MODE_BR:          w_target_next = w_br_target;
                default: begin
                    w_target_next       = w_ras_empty ? '0 : w_ras_dout;
                    w_target_valid_next = !w_ras_empty;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_target       <= '0;
            r_target_valid <= 1'b0;
        end else begin
            r_target       <= w_target_next;
            r_target_valid <= w_target_valid_next;
        end
    end

    assign bus.Target       = r_target;
    assign bus.TargetValid  = r_target_valid;
    assign bus.RasEmpty     = w_ras_empty;
    assign bus.RasOverflow  = w_ras_overflow;
    assign bus.RasUnderflow = w_ras_underflow;
endmodule

// File: tb/tb_jump_target_unit.sv
// Directed bench for jump_target_unit: a queue-based reference model checked
// every cycle, plus literal expectations from the worked examples.
module tb_jump_target_unit;
    import jtu_pkg::*;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 26;
    localparam int IMM_W  = 16;
    localparam int DEPTH  = 4;

    logic Clk;
    logic Reset_n;
    int   n_vec;
    int   n_fail;

    jump_target_unit_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .IMM_W(IMM_W)) bus ();

    jump_target_unit #(
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W),
        .IMM_W     (IMM_W),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the stack is an unbounded queue trimmed to DEPTH entries.
    logic [31:0] ras_q[$];
    logic [31:0] m_target;
    logic        m_tv;
    logic        m_ovf;
    logic        m_udf;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_target = 0; m_tv = 0; m_ovf = 0; m_udf = 0;
            ras_q.delete();
        end else begin
            m_tv = 0; m_ovf = 0; m_udf = 0;
            if (bus.Flush) begin
                ras_q.delete();
            end else if (bus.Valid) begin
                case (bus.Mode)
                    MODE_J, MODE_JAL: begin
                        m_target = ((bus.PCAddResult >> (IDX_W + 2)) << (IDX_W + 2))
                                   | (32'(bus.InstrIndex) * 4);
                        m_tv = 1;
                        if (bus.Mode == MODE_JAL) begin
                            ras_q.push_back(bus.PCAddResult);
                            if (ras_q.size() > DEPTH) begin
                                void'(ras_q.pop_front());
                                m_ovf = 1;
                            end
                        end
                    end
                    MODE_JR: begin
                        if (ras_q.size() == 0) begin
                            m_target = 0;
                            m_udf = 1;
                        end else begin
                            m_target = ras_q.pop_back();
                            m_tv = 1;
                        end
                    end
                    default: begin
                        logic signed [31:0] off;
                        off = 32'(signed'(bus.Imm));
                        m_target = bus.PCAddResult + off * 4;
                        m_tv = 1;
                    end
                endcase
            end
        end
    end

    always @(negedge Clk) begin
        chk("model_Target", bus.Target, m_target);
        chk("model_TargetValid", 32'(bus.TargetValid), 32'(m_tv));
        chk("model_RasEmpty", 32'(bus.RasEmpty), 32'(ras_q.size() == 0));
        chk("model_RasOverflow", 32'(bus.RasOverflow), 32'(m_ovf));
        chk("model_RasUnderflow", 32'(bus.RasUnderflow), 32'(m_udf));
    end

    // Called at a falling edge; returns at the next falling edge with results visible.
    task automatic op(input logic v, input logic [1:0] m, input logic [31:0] pc,
                      input logic [25:0] idx, input logic [15:0] imm, input logic fl);
        bus.Valid = v; bus.Mode = m; bus.PCAddResult = pc;
        bus.InstrIndex = idx; bus.Imm = imm; bus.Flush = fl;
        @(posedge Clk);
        @(negedge Clk);
        $display("op v=%0b mode=%0d flush=%0b pc=%h idx=%h imm=%h -> Target=%h TV=%0b E=%0b O=%0b U=%0b",
                 v, m, fl, pc, idx, imm, bus.Target, bus.TargetValid,
                 bus.RasEmpty, bus.RasOverflow, bus.RasUnderflow);
    endtask

    task automatic idle();
        op(1'b0, MODE_J, 32'h0, 26'h0, 16'h0, 1'b0);
    endtask

    initial begin
        n_vec = 0; n_fail = 0;
        Reset_n = 1'b0;
        bus.Valid = 0; bus.Mode = MODE_J; bus.PCAddResult = 0;
        bus.InstrIndex = 0; bus.Imm = 0; bus.Flush = 0;
        #1;
        chk("reset_Target", bus.Target, 32'h0);
        chk("reset_RasEmpty", 32'(bus.RasEmpty), 32'h1);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        op(1'b1, MODE_J, 32'h4000_0010, 26'h40, 16'h0, 1'b0);
        chk("J_Target", bus.Target, 32'h4000_0100);
        chk("J_TargetValid", 32'(bus.TargetValid), 32'h1);
        idle();
        chk("idle_hold_Target", bus.Target, 32'h4000_0100);
        chk("idle_TargetValid", 32'(bus.TargetValid), 32'h0);

        op(1'b1, MODE_BR, 32'h0040_0020, 26'h0, 16'hFFFE, 1'b0);
        chk("BR_neg_Target", bus.Target, 32'h0040_0018);
        op(1'b1, MODE_BR, 32'h0040_0020, 26'h0, 16'h0004, 1'b0);
        chk("BR_pos_Target", bus.Target, 32'h0040_0030);
        op(1'b1, MODE_BR, 32'hFFFF_FFFC, 26'h0, 16'h0002, 1'b0);
        chk("BR_wrap_Target", bus.Target, 32'h0000_0004);

        op(1'b1, MODE_JAL, 32'h0040_0008, 26'h10, 16'h0, 1'b0);
        chk("JAL_RasEmpty", 32'(bus.RasEmpty), 32'h0);
        op(1'b1, MODE_JR, 32'h0, 26'h0, 16'h0, 1'b0);
        chk("JR_Target", bus.Target, 32'h0040_0008);
        chk("JR_RasEmpty", 32'(bus.RasEmpty), 32'h1);

        for (int i = 1; i <= 5; i++) begin
            op(1'b1, MODE_JAL, 32'(i) * 32'h100, 26'(i), 16'h0, 1'b0);
            chk("JAL_fill_Overflow", 32'(bus.RasOverflow), 32'(i == 5));
        end
        for (int i = 5; i >= 2; i--) begin
            op(1'b1, MODE_JR, 32'h0, 26'h0, 16'h0, 1'b0);
            chk("JR_drain_Target", bus.Target, 32'(i) * 32'h100);
        end
        op(1'b1, MODE_JR, 32'h0, 26'h0, 16'h0, 1'b0);
        chk("JR_under_Underflow", 32'(bus.RasUnderflow), 32'h1);
        chk("JR_under_TargetValid", 32'(bus.TargetValid), 32'h0);
        chk("JR_under_Target", bus.Target, 32'h0);
        idle();
        chk("under_pulse_cleared", 32'(bus.RasUnderflow), 32'h0);

        op(1'b1, MODE_JAL, 32'h0000_0A00, 26'h1, 16'h0, 1'b0);
        op(1'b1, MODE_JAL, 32'h0000_0B00, 26'h2, 16'h0, 1'b0);
        op(1'b1, MODE_JAL, 32'h0000_0C00, 26'h3, 16'h0, 1'b1);
        chk("flush_RasEmpty", 32'(bus.RasEmpty), 32'h1);
        chk("flush_TargetValid", 32'(bus.TargetValid), 32'h0);
        op(1'b1, MODE_JR, 32'h0, 26'h0, 16'h0, 1'b0);
        chk("flush_JR_Underflow", 32'(bus.RasUnderflow), 32'h1);

        op(1'b1, MODE_JAL, 32'h0000_1000, 26'h11, 16'h0, 1'b0);
        op(1'b1, MODE_JAL, 32'h0000_2000, 26'h22, 16'h0, 1'b0);
        op(1'b1, MODE_JAL, 32'h0000_3000, 26'h33, 16'h0, 1'b0);
        chk("pre_reset_Target", bus.Target, 32'h0000_00CC);
        bus.Valid = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_reset_Target", bus.Target, 32'h0);
        chk("async_reset_TargetValid", 32'(bus.TargetValid), 32'h0);
        chk("async_reset_RasEmpty", 32'(bus.RasEmpty), 32'h1);
        @(negedge Clk);
        Reset_n = 1'b1;
        op(1'b1, MODE_JR, 32'h0, 26'h0, 16'h0, 1'b0);
        chk("post_reset_JR_Underflow", 32'(bus.RasUnderflow), 32'h1);
        chk("post_reset_JR_TargetValid", 32'(bus.TargetValid), 32'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
